// File: rtl/nor_chain_decoder_pkg.sv
// Shared types and constants for the NOR-chain decoder.
package nor_chain_decoder_pkg;

  localparam int CODE_W = 4;
  localparam int TGT_W  = 3;

  localparam logic [CODE_W-1:0] LAST_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/nor_chain_decoder_eval.sv
// Combinational model of the three-stage NOR cascade: code {a,b,c,d} -> {e,f,g}.
module nor_chain_eval
  import nor_chain_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [TGT_W-1:0]  tgt
);

  logic e;
  logic f;
  logic g;

  assign e   = ~(code[3] | code[2]);
  assign f   = ~(e | code[1]);
  assign g   = ~(f | code[0]);
  assign tgt = {e, f, g};

endmodule

// File: rtl/nor_chain_decoder.sv
// Scans all 16 input codes and streams those whose NOR-chain output equals the target.
// Optional match counter enabled by defining NOR_CHAIN_DECODER_MATCH_CNT_EN.
module nor_chain_decoder
  import nor_chain_decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [TGT_W-1:0]  req_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              done
`ifdef NOR_CHAIN_DECODER_MATCH_CNT_EN
  ,
  output logic [4:0]        match_cnt
`endif
);

  state_t             state;
  logic [CODE_W-1:0]  idx;
  logic [TGT_W-1:0]   target_q;
  logic [TGT_W-1:0]   eval_tgt;

  nor_chain_eval u_eval (
    .code (idx),
    .tgt  (eval_tgt)
  );

  assign req_ready = (state == IDLE);

  // idx keeps pointing at the emitted code during EMIT so the scan resumes after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      target_q  <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            target_q <= req_target;
            idx      <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (eval_tgt == target_q) begin
            out_code  <= idx;
            out_valid <= 1'b1;
            state     <= EMIT;
          end else if (idx == LAST_CODE) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx == LAST_CODE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= SCAN;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NOR_CHAIN_DECODER_MATCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      match_cnt <= '0;
    end else if (out_valid && out_ready) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nor_chain_decoder.sv
// Scoreboard bench for nor_chain_decoder; expected codes come from a reference NOR-chain model.
module tb_nor_chain_decoder;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_target;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       done;
`ifdef NOR_CHAIN_DECODER_MATCH_CNT_EN
  logic [4:0] match_cnt;
`endif

  int passed = 0;
  int total  = 0;

  nor_chain_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .done       (done)
`ifdef NOR_CHAIN_DECODER_MATCH_CNT_EN
    ,
    .match_cnt  (match_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [2:0] nor_model(input logic [3:0] x);
    logic e, f, g;
    e = ~(x[3] | x[2]);
    f = ~(e | x[1]);
    g = ~(f | x[0]);
    return {e, f, g};
  endfunction

  // One full request: expected codes are queued at request time and popped on each handshake
  task automatic run_scan(input logic [2:0] target, input int stall_n, input bit toggle,
                          input int exp_done, input string name);
    logic [3:0] q[$];
    int cyc, stall_cnt, valid_cycles, exp_matches;
    bit got_done;
    for (int c = 0; c < 16; c++)
      if (nor_model(4'(c)) == target) q.push_back(4'(c));
    exp_matches = q.size();
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("[TB] FAIL %s idle_ready: got %b expected 1", name, req_ready);
    else passed++;
    req_valid  = 1'b1;
    req_target = target;
    out_ready  = (stall_n == 0);
    @(posedge clk);
    cyc = 0; stall_cnt = 0; valid_cycles = 0; got_done = 0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (toggle) req_target = ~req_target;
      else req_valid = 1'b0;
      if (done) begin
        got_done  = 1;
        req_valid = 1'b0;
        total++;
        if (cyc != exp_done) $display("[TB] FAIL %s done_cycle: got %0d expected %0d", name, cyc, exp_done);
        else passed++;
        total++;
        if (q.size() != 0) $display("[TB] FAIL %s missing_codes: got %0d left expected 0", name, q.size());
        else passed++;
        total++;
        if (valid_cycles != exp_matches * (stall_n + 1))
          $display("[TB] FAIL %s valid_cycles: got %0d expected %0d", name, valid_cycles, exp_matches * (stall_n + 1));
        else passed++;
`ifdef NOR_CHAIN_DECODER_MATCH_CNT_EN
        total++;
        if (match_cnt !== 5'(exp_matches))
          $display("[TB] FAIL %s match_cnt: got %0d expected %0d", name, match_cnt, exp_matches);
        else passed++;
`endif
      end else begin
        total++;
        if (req_ready !== 1'b0) $display("[TB] FAIL %s busy_ready: got %b expected 0 at cycle %0d", name, req_ready, cyc);
        else passed++;
      end
      if (out_valid) begin
        valid_cycles++;
        total++;
        if (q.size() == 0) $display("[TB] FAIL %s unexpected_code: got %h expected none", name, out_code);
        else if (out_code !== q[0]) $display("[TB] FAIL %s out_code: got %h expected %h", name, out_code, q[0]);
        else passed++;
        if (stall_cnt < stall_n) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          stall_cnt = 0;
          if (q.size() > 0) void'(q.pop_front());
        end
      end else begin
        out_ready = (stall_n == 0);
      end
    end
    if (!got_done) begin
      total++;
      $display("[TB] FAIL %s timeout: got no done expected done at cycle %0d", name, exp_done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || req_ready !== 1'b1)
      $display("[TB] FAIL %s after_done: got done=%b ready=%b expected done=0 ready=1", name, done, req_ready);
    else passed++;
`ifdef NOR_CHAIN_DECODER_MATCH_CNT_EN
    total++;
    if (match_cnt !== 5'(exp_matches))
      $display("[TB] FAIL %s match_cnt_hold: got %0d expected %0d", name, match_cnt, exp_matches);
    else passed++;
`endif
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_target = 3'b000; out_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0 || out_code !== 4'h0)
      $display("[TB] FAIL reset_state: got ready=%b valid=%b done=%b code=%h expected 1 0 0 0",
               req_ready, out_valid, done, out_code);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_matches();
    run_scan(3'b101, 0, 1'b0, 19, "tgt101");
  endtask

  task automatic test_six_matches();
    run_scan(3'b010, 0, 1'b0, 23, "tgt010");
  endtask

  task automatic test_no_match();
    run_scan(3'b011, 0, 1'b0, 17, "tgt011");
    run_scan(3'b111, 0, 1'b0, 17, "tgt111");
    run_scan(3'b110, 0, 1'b0, 17, "tgt110");
  endtask

  task automatic test_stall();
    run_scan(3'b001, 4, 1'b0, 32, "stall001");
  endtask

  task automatic test_reset_mid_emit();
    int n;
    bit saw_done;
    bit saw_valid;
    @(negedge clk);
    req_valid = 1'b1; req_target = 3'b000; out_ready = 1'b0;
    @(posedge clk);
    n = 0;
    saw_valid = 0;
    while (!saw_valid && n < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      n++;
      saw_valid = out_valid;
    end
    total++;
    if (!saw_valid) $display("[TB] FAIL rst_emit_reach: got no out_valid expected out_valid");
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || req_ready !== 1'b1 || out_code !== 4'h0 || done !== 1'b0)
      $display("[TB] FAIL rst_emit_drop: got valid=%b ready=%b code=%h done=%b expected 0 1 0 0",
               out_valid, req_ready, out_code, done);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || out_valid) saw_done = 1;
    end
    total++;
    if (saw_done) $display("[TB] FAIL rst_emit_quiet: got activity expected none after reset");
    else passed++;
    run_scan(3'b000, 0, 1'b0, 20, "tgt000");
  endtask

  task automatic test_back_to_back();
    run_scan(3'b101, 0, 1'b1, 19, "toggle101");
    run_scan(3'b100, 0, 1'b0, 19, "tgt100");
  endtask

  initial begin
    test_reset();
    test_two_matches();
    test_six_matches();
    test_no_match();
    test_stall();
    test_reset_mid_emit();
    test_back_to_back();
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
